// File: rtl/chan_fifo_bank_if.sv
// Push/pop port bundle and status flags of the channelised FIFO bank.
interface chan_fifo_bank_if #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int DEPTH_LOG2 = 4
);
    localparam int CH = 2 ** ADDR_W;

    logic                  push_valid;
    logic [ADDR_W-1:0]     push_addr;
    logic [DATA_W-1:0]     push_data;
    logic                  push_ready;
    logic                  pop_req;
    logic [ADDR_W-1:0]     pop_addr;
    logic [DATA_W-1:0]     pop_data;
    logic                  pop_data_vld;
    logic [DEPTH_LOG2:0]   pop_level;
    logic [CH-1:0]         full;
    logic [CH-1:0]         empty;
    logic [CH-1:0]         almost_full;
    logic [CH-1:0]         almost_empty;
    logic [CH-1:0]         overflow;
    logic [CH-1:0]         underflow;
    logic                  clear_err;

    modport master (
        output push_valid, push_addr, push_data, pop_req, pop_addr, clear_err,
        input  push_ready, pop_data, pop_data_vld, pop_level,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push_valid, push_addr, push_data, pop_req, pop_addr, clear_err,
        output push_ready, pop_data, pop_data_vld, pop_level,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/chan_fifo_bank.sv
// Bank of independent pointer-based circular FIFOs, one shared push port and one shared pop port,
// each steered to a channel by its address. Sticky overflow/underflow per channel.
module chan_fifo_bank #(
    parameter int DATA_W             = 8,
    parameter int ADDR_W             = 2,
    parameter int DEPTH_LOG2         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    chan_fifo_bank_if.slave bus
);
    localparam int CH    = 2 ** ADDR_W;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [PW-1:0]     wr_ptr_q [CH];
    logic [PW-1:0]     wr_ptr_d [CH];
    logic [PW-1:0]     rd_ptr_q [CH];
    logic [PW-1:0]     rd_ptr_d [CH];
    logic [DATA_W-1:0] mem_q    [CH][DEPTH];

    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_vld_q, pop_vld_d;
    logic [CH-1:0]     ovf_q, ovf_d;
    logic [CH-1:0]     udf_q, udf_d;

    logic [PW-1:0]     level [CH];
    logic [CH-1:0]     full_w, empty_w, afull_w, aempty_w;
    logic              push_acc, pop_acc;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

    // Flags come straight from the pointers; the extra MSB separates full from empty.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            level[c]    = wr_ptr_q[c] - rd_ptr_q[c];
            full_w[c]   = (level[c] == PW'(DEPTH));
            empty_w[c]  = (level[c] == '0);
            afull_w[c]  = (level[c] >= PW'(ALMOST_FULL_LEVEL));
            aempty_w[c] = (level[c] <= PW'(ALMOST_EMPTY_LEVEL));
        end
    end

    assign push_acc = bus.push_valid && !full_w[bus.push_addr];
    assign pop_acc  = bus.pop_req && !empty_w[bus.pop_addr];
    assign wr_idx   = wr_ptr_q[bus.push_addr][DEPTH_LOG2-1:0];
    assign rd_idx   = rd_ptr_q[bus.pop_addr][DEPTH_LOG2-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_data_d = pop_data_q;
        pop_vld_d  = 1'b0;
        ovf_d      = bus.clear_err ? '0 : ovf_q;
        udf_d      = bus.clear_err ? '0 : udf_q;
        if (push_acc) begin
            wr_ptr_d[bus.push_addr] = wr_ptr_q[bus.push_addr] + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d[bus.pop_addr] = rd_ptr_q[bus.pop_addr] + 1'b1;
            pop_data_d             = mem_q[bus.pop_addr][rd_idx];
            pop_vld_d              = 1'b1;
        end
        // An error event in the same cycle as clear_err leaves the flag set.
        if (bus.push_valid && full_w[bus.push_addr]) begin
            ovf_d[bus.push_addr] = 1'b1;
        end
        if (bus.pop_req && empty_w[bus.pop_addr]) begin
            udf_d[bus.pop_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            pop_data_q <= '0;
            pop_vld_q  <= 1'b0;
            ovf_q      <= '0;
            udf_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pop_data_q <= pop_data_d;
            pop_vld_q  <= pop_vld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is never reset; resetting the pointers is enough to discard it.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[bus.push_addr][wr_idx] <= bus.push_data;
        end
    end

    assign bus.push_ready   = !full_w[bus.push_addr];
    assign bus.pop_data     = pop_data_q;
    assign bus.pop_data_vld = pop_vld_q;
    assign bus.pop_level    = level[bus.pop_addr];
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = afull_w;
    assign bus.almost_empty = aempty_w;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_chan_fifo_bank.sv
// Directed bench for chan_fifo_bank: 4 channels of depth 16, hand-computed expectations.
module tb_chan_fifo_bank;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    chan_fifo_bank_if #(.DATA_W(8), .ADDR_W(2), .DEPTH_LOG2(4)) bus ();

    chan_fifo_bank #(
        .DATA_W(8), .ADDR_W(2), .DEPTH_LOG2(4),
        .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
        bus.clear_err  = 1'b0;
    endtask

    task automatic push1(input logic [1:0] a, input logic [7:0] d);
        bus.push_valid = 1'b1;
        bus.push_addr  = a;
        bus.push_data  = d;
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        bus.push_addr = 2'd0;
        bus.push_data = 8'h00;
        bus.pop_addr  = 2'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_empty", {28'd0, bus.empty}, 32'hF);
        chk("reset_full", {28'd0, bus.full}, 32'h0);
        chk("reset_aempty", {28'd0, bus.almost_empty}, 32'hF);
        chk("reset_afull", {28'd0, bus.almost_full}, 32'h0);
        chk("reset_vld", {31'd0, bus.pop_data_vld}, 32'h0);
        chk("reset_errs", {24'd0, bus.overflow, bus.underflow}, 32'h0);
    endtask

    task automatic test_fill_ch2();
        for (int k = 1; k <= 16; k++) begin
            push1(2'd2, 8'(k));
            if (k == 2)  chk("fill_aempty_at2", {31'd0, bus.almost_empty[2]}, 32'h1);
            if (k == 3)  chk("fill_aempty_at3", {31'd0, bus.almost_empty[2]}, 32'h0);
            if (k == 11) chk("fill_afull_at11", {31'd0, bus.almost_full[2]}, 32'h0);
            if (k == 12) chk("fill_afull_at12", {31'd0, bus.almost_full[2]}, 32'h1);
            if (k == 15) chk("fill_full_at15", {31'd0, bus.full[2]}, 32'h0);
        end
        chk("fill_full", {28'd0, bus.full}, 32'h4);
        bus.push_addr = 2'd2;
        #1;
        chk("fill_push_ready", {31'd0, bus.push_ready}, 32'h0);
        push1(2'd2, 8'd17);
        chk("fill_overflow", {28'd0, bus.overflow}, 32'h4);
        chk("fill_others_empty", {28'd0, bus.empty}, 32'hB);
        bus.pop_addr = 2'd2;
        #1;
        chk("fill_level16", {27'd0, bus.pop_level}, 32'd16);
    endtask

    task automatic test_drain_ch2();
        for (int i = 1; i <= 16; i++) begin
            bus.pop_req  = 1'b1;
            bus.pop_addr = 2'd2;
            step();
            chk("drain_data", {24'd0, bus.pop_data}, 32'(i));
            chk("drain_vld", {31'd0, bus.pop_data_vld}, 32'h1);
        end
        bus.pop_req = 1'b0;
        chk("drain_empty", {31'd0, bus.empty[2]}, 32'h1);
        bus.pop_req = 1'b1;
        step();
        bus.pop_req = 1'b0;
        chk("drain_underflow", {28'd0, bus.underflow}, 32'h4);
        chk("drain_extra_vld", {31'd0, bus.pop_data_vld}, 32'h0);
        chk("drain_hold_data", {24'd0, bus.pop_data}, 32'd16);
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("clear_errs", {24'd0, bus.overflow, bus.underflow}, 32'h0);
    endtask

    task automatic test_same_chan();
        logic [7:0] exp;
        for (int k = 0; k < 5; k++) push1(2'd1, 8'(10 + k));
        for (int k = 0; k < 40; k++) begin
            bus.push_valid = 1'b1;
            bus.push_addr  = 2'd1;
            bus.push_data  = (k == 0) ? 8'hA5 : 8'(k);
            bus.pop_req    = 1'b1;
            bus.pop_addr   = 2'd1;
            step();
            if (k < 5)       exp = 8'(10 + k);
            else if (k == 5) exp = 8'hA5;
            else             exp = 8'(k - 5);
            chk("same_data", {24'd0, bus.pop_data}, {24'd0, exp});
            chk("same_level", {27'd0, bus.pop_level}, 32'd5);
        end
        idle();
        chk("same_vld_last", {31'd0, bus.pop_data_vld}, 32'h1);
    endtask

    task automatic test_diff_chan();
        push1(2'd3, 8'h31);
        push1(2'd3, 8'h32);
        push1(2'd3, 8'h33);
        bus.push_valid = 1'b1;
        bus.push_addr  = 2'd0;
        bus.push_data  = 8'h01;
        bus.pop_req    = 1'b1;
        bus.pop_addr   = 2'd3;
        step();
        idle();
        chk("diff_pop_data", {24'd0, bus.pop_data}, 32'h31);
        chk("diff_pop_vld", {31'd0, bus.pop_data_vld}, 32'h1);
        #1;
        chk("diff_ch3_level", {27'd0, bus.pop_level}, 32'd2);
        bus.pop_addr = 2'd0;
        #1;
        chk("diff_ch0_level", {27'd0, bus.pop_level}, 32'd1);
        bus.pop_req = 1'b1;
        step();
        chk("diff_ch0_data", {24'd0, bus.pop_data}, 32'h01);
        bus.push_valid = 1'b1;
        bus.push_addr  = 2'd0;
        bus.push_data  = 8'h02;
        step();
        idle();
        chk("empty_same_udf", {28'd0, bus.underflow}, 32'h1);
        chk("empty_same_vld", {31'd0, bus.pop_data_vld}, 32'h0);
        chk("empty_same_hold", {24'd0, bus.pop_data}, 32'h01);
        chk("empty_same_level", {27'd0, bus.pop_level}, 32'd1);
    endtask

    task automatic test_full_same();
        for (int i = 0; i < 16; i++) push1(2'd2, 8'(8'h40 + i));
        chk("fs_full", {31'd0, bus.full[2]}, 32'h1);
        bus.push_valid = 1'b1;
        bus.push_addr  = 2'd2;
        bus.push_data  = 8'h99;
        bus.pop_req    = 1'b1;
        bus.pop_addr   = 2'd2;
        #1;
        chk("fs_push_ready", {31'd0, bus.push_ready}, 32'h0);
        step();
        idle();
        chk("fs_overflow", {28'd0, bus.overflow}, 32'h4);
        chk("fs_pop_data", {24'd0, bus.pop_data}, 32'h40);
        chk("fs_pop_vld", {31'd0, bus.pop_data_vld}, 32'h1);
        chk("fs_level", {27'd0, bus.pop_level}, 32'd15);
    endtask

    task automatic test_clear_err();
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("clr_ovf", {28'd0, bus.overflow}, 32'h0);
        chk("clr_udf", {28'd0, bus.underflow}, 32'h0);
        push1(2'd2, 8'h4F);
        bus.clear_err  = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_addr  = 2'd2;
        step();
        idle();
        chk("clr_event_wins", {28'd0, bus.overflow}, 32'h4);
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("clr_again", {28'd0, bus.overflow}, 32'h0);
    endtask

    task automatic test_reset_mid();
        push1(2'd1, 8'h77);
        push1(2'd1, 8'h78);
        bus.pop_addr = 2'd1;
        #1;
        chk("mid_level7", {27'd0, bus.pop_level}, 32'd7);
        bus.pop_req  = 1'b1;
        bus.pop_addr = 2'd3;
        step();
        bus.pop_req  = 1'b0;
        bus.pop_addr = 2'd1;
        chk("mid_vld_before", {31'd0, bus.pop_data_vld}, 32'h1);
        chk("mid_full_before", {28'd0, bus.full}, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_empty", {28'd0, bus.empty}, 32'hF);
        chk("mid_full", {28'd0, bus.full}, 32'h0);
        chk("mid_aempty", {28'd0, bus.almost_empty}, 32'hF);
        chk("mid_afull", {28'd0, bus.almost_full}, 32'h0);
        chk("mid_vld", {31'd0, bus.pop_data_vld}, 32'h0);
        chk("mid_data", {24'd0, bus.pop_data}, 32'h0);
        chk("mid_level", {27'd0, bus.pop_level}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid_after_empty", {28'd0, bus.empty}, 32'hF);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        test_reset();
        test_fill_ch2();
        test_drain_ch2();
        test_same_chan();
        test_diff_chan();
        test_full_same();
        test_clear_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
